// File: rtl/digit_blank_pkg.sv
// digit_blank_pkg
//   Shared defaults and helpers for the display blanking controller.
//   - DW_DEFAULT         : bits per digit code
//   - BLANK_CODE_DEFAULT : code the segment decoder shows as all segments off
//   - get_digit()        : extracts digit idx from a packed digit vector
package digit_blank_pkg;

  localparam int DW_DEFAULT = 4;
  localparam logic [DW_DEFAULT-1:0] BLANK_CODE_DEFAULT = 4'b1111;

  // get_digit() works on fixed-width containers, so callers widen their
  // digit vector to MAX_VEC_W and narrow the result back to their own DW.
  localparam int MAX_VEC_W = 256;
  localparam int MAX_DW    = 8;

  function automatic logic [MAX_DW-1:0] get_digit(
    input logic [MAX_VEC_W-1:0] vec,
    input int                   idx,
    input int                   dw
  );
    logic [MAX_VEC_W-1:0] shifted;
    logic [MAX_DW-1:0]    keep;
    shifted = vec >> (idx * dw);
    // With dw == MAX_DW the shift wraps to zero, so the mask is all ones.
    keep = (MAX_DW'(1) << dw) - MAX_DW'(1);
    return shifted[MAX_DW-1:0] & keep;
  endfunction

endpackage

// File: rtl/blank_tick_div.sv
// blank_tick_div
//   Blink timebase: a counter running 0..BLINK_DIV-1 that toggles the blink
//   phase each time it wraps. A synchronous clear restarts the half-period
//   and forces the visible phase.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset
//     clr    in  synchronous clear (counter -> 0, phase -> 0)
//     phase  out 0 = visible phase, 1 = blanked phase (registered)
module blank_tick_div #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic phase
);

  // A one-cycle half-period still needs a 1-bit counter to keep the code
  // uniform; it simply stays at 0 and wraps every cycle.
  localparam int          CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          phase_reg, phase_next;
  logic          wrap;

  assign wrap = (cnt_reg == LAST);

  always_comb begin
    cnt_next   = cnt_reg + CW'(1);
    phase_next = phase_reg;
    if (clr) begin
      // Clear outranks a wrap on the same edge.
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (wrap) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/digit_blank_ctrl.sv
// digit_blank_ctrl
//   Blanking stage between the digit formatter and the segment decoder.
//   A digit is replaced by BLANK_CODE when it is a suppressed leading zero,
//   when it is selected for blinking during the blanked phase, or when the
//   whole display is asleep after an idle timeout. All outputs are
//   registered; the decision uses the inputs and state present before the
//   edge (one cycle latency).
//   Ports:
//     clk         in  system clock
//     rst_n       in  asynchronous active-low reset
//     digits_in   in  DIGITS*DW digit codes, digit i at [i*DW +: DW]
//     sw          in  0 = number mode (suppression allowed), 1 = raw mode
//     lz_en       in  leading-zero suppression enable (number mode only)
//     blink_sel   in  per-digit blink enable
//     activity    in  key/command pulse; restarts idle timer, wakes display
//     digits_out  out digit codes after blanking
//     blank_mask  out 1 = digit i is driven with BLANK_CODE
//     blink_phase out 0 = visible phase, 1 = blanked phase
//     sleeping    out display is in idle sleep
module digit_blank_ctrl
  import digit_blank_pkg::*;
#(
  parameter int            DIGITS       = 4,
  parameter int            DW           = DW_DEFAULT,
  parameter logic [DW-1:0] BLANK_CODE   = DW'(BLANK_CODE_DEFAULT),
  parameter int            BLINK_DIV    = 25000000,
  parameter int            IDLE_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIGITS*DW-1:0] digits_in,
  input  logic                 sw,
  input  logic                 lz_en,
  input  logic [DIGITS-1:0]    blink_sel,
  input  logic                 activity,
  output logic [DIGITS*DW-1:0] digits_out,
  output logic [DIGITS-1:0]    blank_mask,
  output logic                 blink_phase,
  output logic                 sleeping
);

  localparam int            IW       = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  logic sleeping_w;
  logic wake;
  logic phase_w;
  logic supp_en;

  // Activity while asleep restarts the blink timebase too, so a blinking
  // digit starts in its visible phase once the display is back.
  assign wake = activity & sleeping_w;

  blank_tick_div #(
    .BLINK_DIV (BLINK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wake),
    .phase (phase_w)
  );

  // ---------------------------------------------------------------- idle --
  generate
    if (IDLE_TIMEOUT > 0) begin : g_idle
      logic [IW-1:0] idle_reg, idle_next;
      logic          sleeping_reg;

      always_comb begin
        if (activity) begin
          idle_next = '0;
        end else if (idle_reg == IDLE_MAX) begin
          idle_next = idle_reg;
        end else begin
          idle_next = idle_reg + IW'(1);
        end
      end

      // Sleep follows the next count, so activity on the edge that would
      // reach the timeout keeps the display awake.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          idle_reg     <= '0;
          sleeping_reg <= 1'b0;
        end else begin
          idle_reg     <= idle_next;
          sleeping_reg <= (idle_next == IDLE_MAX);
        end
      end

      assign sleeping_w = sleeping_reg;
    end else begin : g_no_idle
      assign sleeping_w = 1'b0;
    end
  endgenerate

  // ------------------------------------------------------ blank decision --
  assign supp_en = ~sw & lz_en;

  logic [DW-1:0]       digit_w [DIGITS];
  logic [DIGITS-1:0]   zero_w;
  logic [DIGITS-1:0]   upper_zero_w;  // every digit above i is zero
  logic [DIGITS-1:0]   lz_w;
  logic [DIGITS-1:0]   bl_w;
  logic [DIGITS-1:0]   blank_w;
  logic [DIGITS*DW-1:0] out_next;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_w[gi] = DW'(get_digit(MAX_VEC_W'(digits_in), gi, DW));
      assign zero_w[gi]  = (digit_w[gi] == '0);

      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero_w[gi] = 1'b1;
      end else begin : g_lower
        assign upper_zero_w[gi] = upper_zero_w[gi+1] & zero_w[gi+1];
      end

      // Digit 0 is exempt so a value of zero still shows a single "0".
      if (gi == 0) begin : g_lsd
        assign lz_w[gi] = 1'b0;
      end else begin : g_msd
        assign lz_w[gi] = supp_en & zero_w[gi] & upper_zero_w[gi];
      end

      assign bl_w[gi]    = blink_sel[gi] & phase_w;
      assign blank_w[gi] = sleeping_w | lz_w[gi] | bl_w[gi];
      assign out_next[gi*DW +: DW] = blank_w[gi] ? BLANK_CODE : digit_w[gi];
    end
  endgenerate

  // ------------------------------------------------------ output register --
  logic [DIGITS*DW-1:0] digits_out_reg;
  logic [DIGITS-1:0]    blank_mask_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out_reg <= {DIGITS{BLANK_CODE}};
      blank_mask_reg <= '1;
    end else begin
      digits_out_reg <= out_next;
      blank_mask_reg <= blank_w;
    end
  end

  assign digits_out  = digits_out_reg;
  assign blank_mask  = blank_mask_reg;
  assign blink_phase = phase_w;
  assign sleeping    = sleeping_w;

endmodule

// File: tb/tb_digit_blank_ctrl.sv
// tb_digit_blank_ctrl
//   Directed bench for digit_blank_ctrl with DIGITS=4, BLINK_DIV=4,
//   IDLE_TIMEOUT=10. Edges after reset release are numbered E1, E2, ...;
//   the blink phase toggles on every fourth edge and an output registered
//   at edge k uses the phase and sleep state left by edge k-1.
module tb_digit_blank_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        sw;
  logic        lz_en;
  logic [3:0]  blink_sel;
  logic        activity;
  logic [15:0] digits_out;
  logic [3:0]  blank_mask;
  logic        blink_phase;
  logic        sleeping;

  int checks   = 0;
  int failures = 0;

  // Expected blink pattern for E7..E24: digit-0 blanked, and phase after edge.
  bit exp_blk [7:24];
  bit exp_ph  [7:24];

  digit_blank_ctrl #(
    .DIGITS       (4),
    .DW           (4),
    .BLANK_CODE   (4'hF),
    .BLINK_DIV    (4),
    .IDLE_TIMEOUT (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .sw          (sw),
    .lz_en       (lz_en),
    .blink_sel   (blink_sel),
    .activity    (activity),
    .digits_out  (digits_out),
    .blank_mask  (blank_mask),
    .blink_phase (blink_phase),
    .sleeping    (sleeping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s ok value=%0h", tag, obs);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given activity level; outputs sampled 1 ns later.
  task automatic step(input logic act);
    activity = act;
    @(posedge clk);
    #1;
    activity = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_blk = '{1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};
    exp_ph  = '{1,0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0};

    rst_n     = 1'b1;
    digits_in = 16'h1234;
    sw        = 1'b0;
    lz_en     = 1'b0;
    blink_sel = 4'b0000;
    activity  = 1'b0;

    // Reset asserted before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_async_out", digits_out, 16'hFFFF);
    chk("rst_async_mask", blank_mask, 4'hF);
    chk("rst_async_phase", blink_phase, 1'b0);
    chk("rst_async_sleep", sleeping, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_out", digits_out, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // E1: first valid output.
    step(1'b0);
    chk("e1_out", digits_out, 16'h1234);
    chk("e1_mask", blank_mask, 4'h0);

    // E2..E6: leading-zero cases.
    digits_in = 16'h0070; lz_en = 1'b1;
    step(1'b0);
    chk("lz_0070_out", digits_out, 16'hFF70);
    chk("lz_0070_mask", blank_mask, 4'b1100);

    digits_in = 16'h0000;
    step(1'b0);
    chk("lz_0000_out", digits_out, 16'hFFF0);
    chk("lz_0000_mask", blank_mask, 4'b1110);

    sw = 1'b1;
    step(1'b0);
    chk("raw_0000_out", digits_out, 16'h0000);
    chk("raw_0000_mask", blank_mask, 4'b0000);
    chk("e4_phase", blink_phase, 1'b1);

    sw = 1'b0; digits_in = 16'h0F05;
    step(1'b0);
    chk("lz_0f05_out", digits_out, 16'hFF05);
    chk("lz_0f05_mask", blank_mask, 4'b1000);

    lz_en = 1'b0; digits_in = 16'h0070;
    step(1'b0);
    chk("lzoff_0070_out", digits_out, 16'h0070);
    chk("lzoff_0070_mask", blank_mask, 4'b0000);

    // E7..E24: blink digit 0, activity every 5 edges.
    digits_in = 16'h5678; blink_sel = 4'b0001; lz_en = 1'b1;
    for (int k = 7; k <= 24; k++) begin
      step(k == 7 || k == 12 || k == 17 || k == 22);
      chk($sformatf("blink_out_e%0d", k), digits_out, exp_blk[k] ? 16'h567F : 16'h5678);
      chk($sformatf("blink_mask_e%0d", k), blank_mask, exp_blk[k] ? 4'b0001 : 4'b0000);
      chk($sformatf("blink_phase_e%0d", k), blink_phase, exp_ph[k]);
      chk($sformatf("blink_sleep_e%0d", k), sleeping, 1'b0);
    end

    // E25..E43: idle count reaches 10 at E32 and holds.
    for (int k = 25; k <= 43; k++) begin
      step(1'b0);
      if (k == 31) chk("sleep_e31", sleeping, 1'b0);
      if (k == 32) chk("sleep_e32", sleeping, 1'b1);
      if (k == 36) chk("sleep_phase_e36", blink_phase, 1'b1);
      if (k >= 33) begin
        chk($sformatf("sleep_out_e%0d", k), digits_out, 16'hFFFF);
        chk($sformatf("sleep_mask_e%0d", k), blank_mask, 4'hF);
        chk($sformatf("sleep_hold_e%0d", k), sleeping, 1'b1);
      end
    end

    // E44: wake on the same edge as a blink wrap.
    step(1'b1);
    chk("wake_sleep_e44", sleeping, 1'b0);
    chk("wake_phase_e44", blink_phase, 1'b0);
    step(1'b0);
    chk("wake_out_e45", digits_out, 16'h5678);
    chk("wake_mask_e45", blank_mask, 4'b0000);
    chk("wake_phase_e45", blink_phase, 1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("wake_phase_e48", blink_phase, 1'b1);

    // E49..E54: activity exactly when the count would reach 10.
    for (int k = 49; k <= 53; k++) begin
      step(1'b0);
      if (k == 53) chk("race_sleep_e53", sleeping, 1'b0);
    end
    step(1'b1);
    chk("race_sleep_e54", sleeping, 1'b0);
    chk("race_out_e54", digits_out, 16'h5678);

    // E55..E65: fall asleep again in the blanked blink phase.
    for (int k = 55; k <= 64; k++) begin
      step(1'b0);
      if (k == 63) chk("resleep_e63", sleeping, 1'b0);
      if (k == 64) begin
        chk("resleep_e64", sleeping, 1'b1);
        chk("resleep_phase_e64", blink_phase, 1'b1);
      end
    end
    step(1'b0);
    chk("resleep_out_e65", digits_out, 16'hFFFF);
    chk("resleep_phase_e65", blink_phase, 1'b1);

    // Mid-operation reset between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", digits_out, 16'hFFFF);
    chk("midrst_mask", blank_mask, 4'hF);
    chk("midrst_phase", blink_phase, 1'b0);
    chk("midrst_sleep", sleeping, 1'b0);
    @(posedge clk); #1;
    chk("midrst_hold_phase", blink_phase, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    chk("post_rst_out", digits_out, 16'h5678);
    chk("post_rst_mask", blank_mask, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
